// File: rtl/controlador_matriz.sv
// controlador_matriz: arbitrates a single-port bitmap matrix between
// per-cycle lookups and queued read-modify-write single-bit updates.
// Lookups win by default. Queued updates take the port when no lookup is
// waiting, when the queue is full, or after a bounded run of lookups.
`timescale 1ns/1ps
module controlador_matriz #(
   parameter int  NUM_CLUSTERS  = 8,
   parameter int  TAM_HASH      = 8,
   parameter int  PROF_FILA     = 4,
   parameter int  LIMITE_ESPERA = 4,
   localparam int CW            = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_leitura,
   input  logic [TAM_HASH-1:0]     hash_leitura,
   input  logic                    req_escrita,
   input  logic [TAM_HASH-1:0]     hash_escrita,
   input  logic [CW-1:0]           cluster_escrita,
   input  logic                    valor_escrita,
   output logic                    aceita_escrita,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [TAM_HASH-1:0]     mem_endereco,
   output logic [NUM_CLUSTERS-1:0] mem_dado_escrita,
   input  logic [NUM_CLUSTERS-1:0] mem_dado_leitura,
   output logic                    leitura_valida,
   output logic [NUM_CLUSTERS-1:0] bitmap_lido,
   output logic                    trava
);

   localparam int PW   = (PROF_FILA > 1) ? $clog2(PROF_FILA) : 1;
   localparam int CNTW = $clog2(PROF_FILA + 1);
   localparam int EW   = (LIMITE_ESPERA > 0) ? $clog2(LIMITE_ESPERA + 1) : 1;

   typedef enum logic [1:0] {OCIOSO, RMW_LE, RMW_ESCREVE} estado_t;

   typedef struct packed {
      logic [TAM_HASH-1:0] hash;
      logic [CW-1:0]       cluster;
      logic                valor;
   } entrada_t;

   entrada_t                fila_q [PROF_FILA];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]         count_q, count_d;
   logic [EW-1:0]           espera_q, espera_d;
   estado_t                 estado_q, estado_d;
   entrada_t                hold_q, hold_d;
   logic [NUM_CLUSTERS-1:0] dado_q, dado_d;
   logic                    valida_q, valida_d;

   logic fila_cheia;
   logic fila_vazia;
   logic push;
   logic grant_leitura;
   logic grant_update;

   // Arbitration, matrix port drive and next-state computation
   always_comb begin
      fila_cheia   = (count_q == CNTW'(PROF_FILA));
      fila_vazia   = (count_q == '0);
      push         = req_escrita && !fila_cheia;
      grant_update = (estado_q == OCIOSO) && !fila_vazia &&
                     (!req_leitura || fila_cheia || (espera_q == EW'(LIMITE_ESPERA)));
      grant_leitura = (estado_q == OCIOSO) && req_leitura && !grant_update;

      mem_en           = 1'b0;
      mem_we           = 1'b0;
      mem_endereco     = '0;
      mem_dado_escrita = '0;
      if (grant_leitura) begin
         mem_en       = 1'b1;
         mem_endereco = hash_leitura;
      end else if (grant_update) begin
         mem_en       = 1'b1;
         mem_endereco = fila_q[rd_ptr_q].hash;
      end else if (estado_q == RMW_ESCREVE) begin
         mem_en           = 1'b1;
         mem_we           = 1'b1;
         mem_endereco     = hold_q.hash;
         mem_dado_escrita = dado_q;
      end

      estado_d = estado_q;
      case (estado_q)
         OCIOSO:      if (grant_update) estado_d = RMW_LE;
         RMW_LE:      estado_d = RMW_ESCREVE;
         RMW_ESCREVE: estado_d = OCIOSO;
         default:     estado_d = OCIOSO;
      endcase

      hold_d = hold_q;
      if (grant_update) hold_d = fila_q[rd_ptr_q];

      dado_d = dado_q;
      if (estado_q == RMW_LE) begin
         dado_d = mem_dado_leitura;
         for (int i = 0; i < NUM_CLUSTERS; i++) begin
            if (CW'(i) == hold_q.cluster) dado_d[i] = hold_q.valor;
         end
      end

      valida_d = grant_leitura;

      espera_d = espera_q;
      if (grant_update || fila_vazia) espera_d = '0;
      else if (grant_leitura && (espera_q != EW'(LIMITE_ESPERA))) espera_d = espera_q + EW'(1);

      count_d = count_q;
      case ({push, grant_update})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase

      wr_ptr_d = wr_ptr_q;
      if (push) wr_ptr_d = (wr_ptr_q == PW'(PROF_FILA - 1)) ? '0 : wr_ptr_q + PW'(1);
      rd_ptr_d = rd_ptr_q;
      if (grant_update) rd_ptr_d = (rd_ptr_q == PW'(PROF_FILA - 1)) ? '0 : rd_ptr_q + PW'(1);
   end

   // Control state, queue bookkeeping and holding registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= OCIOSO;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         espera_q <= '0;
         hold_q   <= '0;
         dado_q   <= '0;
         valida_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         espera_q <= espera_d;
         hold_q   <= hold_d;
         dado_q   <= dado_d;
         valida_q <= valida_d;
      end
   end

   // Queue storage; emptiness is tracked by the counters, so no reset needed
   always_ff @(posedge clk) begin
      if (push) fila_q[wr_ptr_q] <= '{hash: hash_escrita, cluster: cluster_escrita, valor: valor_escrita};
   end

   // Lookup data comes straight from the matrix in the cycle after the grant
   always_comb begin
      aceita_escrita = (count_q != CNTW'(PROF_FILA));
      leitura_valida = valida_q;
      bitmap_lido    = valida_q ? mem_dado_leitura : '0;
      trava          = req_leitura && !grant_leitura;
   end

endmodule

// File: tb/tb_controlador_matriz.sv
// tb_controlador_matriz: directed vectors with a scoreboard for lookup
// results and matrix writes, plus per-cycle checks of stall/accept outputs.
`timescale 1ns/1ps
module tb_controlador_matriz;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_leitura;
   logic [7:0] hash_leitura;
   logic       req_escrita;
   logic [7:0] hash_escrita;
   logic [2:0] cluster_escrita;
   logic       valor_escrita;
   logic       aceita_escrita;
   logic       mem_en;
   logic       mem_we;
   logic [7:0] mem_endereco;
   logic [7:0] mem_dado_escrita;
   logic [7:0] mem_dado_leitura;
   logic       leitura_valida;
   logic [7:0] bitmap_lido;
   logic       trava;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  exp_lookup [$];
   logic [15:0] exp_write  [$];

   typedef struct {
      logic       rl;
      logic [7:0] hl;
      logic       re;
      logic [7:0] he;
      logic [2:0] ce;
      logic       ve;
      logic       t;
      logic       a;
      logic [7:0] bm;
      logic [7:0] wd;
   } vec_t;

   vec_t tab [$];

   controlador_matriz #(
      .NUM_CLUSTERS(8), .TAM_HASH(8), .PROF_FILA(4), .LIMITE_ESPERA(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_leitura(req_leitura), .hash_leitura(hash_leitura),
      .req_escrita(req_escrita), .hash_escrita(hash_escrita),
      .cluster_escrita(cluster_escrita), .valor_escrita(valor_escrita),
      .aceita_escrita(aceita_escrita),
      .mem_en(mem_en), .mem_we(mem_we), .mem_endereco(mem_endereco),
      .mem_dado_escrita(mem_dado_escrita), .mem_dado_leitura(mem_dado_leitura),
      .leitura_valida(leitura_valida), .bitmap_lido(bitmap_lido), .trava(trava)
   );

   always #5 clk = ~clk;

   // Matrix model: synchronous single port, one-cycle read latency
   logic [7:0] mem [256];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'hA5;
      mem[8'h30] = 8'h80;
      for (int i = 0; i < 8; i++) mem[8'h40 + i] = 8'h60 + 8'(i);
      mem_dado_leitura <= 8'h00;
      forever begin
         @(posedge clk);
         if (mem_en) begin
            if (mem_we) mem[mem_endereco] = mem_dado_escrita;
            else mem_dado_leitura <= mem[mem_endereco];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Drive one cycle of inputs shortly after the rising edge, return at the falling edge
   task automatic applyStimulus(input logic rl, input logic [7:0] hl, input logic re,
                                input logic [7:0] he, input logic [2:0] ce, input logic ve);
      @(posedge clk);
      #2;
      req_leitura     = rl;
      hash_leitura    = hl;
      req_escrita     = re;
      hash_escrita    = he;
      cluster_escrita = ce;
      valor_escrita   = ve;
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
   endtask

   function automatic vec_t mk(logic rl, logic [7:0] hl, logic re, logic [7:0] he, logic [2:0] ce,
                               logic ve, logic t, logic a, logic [7:0] bm, logic [7:0] wd);
      vec_t v;
      v.rl = rl; v.hl = hl; v.re = re; v.he = he; v.ce = ce; v.ve = ve;
      v.t = t; v.a = a; v.bm = bm; v.wd = wd;
      return v;
   endfunction

   task automatic runTable(input string tag);
      for (int i = 0; i < tab.size(); i++) begin
         applyStimulus(tab[i].rl, tab[i].hl, tab[i].re, tab[i].he, tab[i].ce, tab[i].ve);
         checkOutput($sformatf("%s_c%0d_trava", tag, i), trava, tab[i].t);
         checkOutput($sformatf("%s_c%0d_aceita", tag, i), aceita_escrita, tab[i].a);
         if (tab[i].rl && !tab[i].t) exp_lookup.push_back(tab[i].bm);
         if (tab[i].re && tab[i].a) exp_write.push_back({tab[i].he, tab[i].wd});
      end
      tab.delete();
   endtask

   // Monitor: pops the scoreboard whenever a lookup result or a matrix write appears
   always @(negedge clk) begin
      if (leitura_valida) begin
         if (exp_lookup.size() == 0) checkOutput("unexpected_lookup", {24'h0, bitmap_lido}, 32'hFFFF_FFFF);
         else checkOutput("lookup_data", {24'h0, bitmap_lido}, {24'h0, exp_lookup.pop_front()});
      end
      if (mem_en && mem_we) begin
         if (exp_write.size() == 0) checkOutput("unexpected_write", {16'h0, mem_endereco, mem_dado_escrita}, 32'hFFFF_FFFF);
         else checkOutput("write_addr_data", {16'h0, mem_endereco, mem_dado_escrita}, {16'h0, exp_write.pop_front()});
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      req_leitura = 1'b0; hash_leitura = 8'h00; req_escrita = 1'b0;
      hash_escrita = 8'h00; cluster_escrita = 3'd0; valor_escrita = 1'b0;

      // Reset state
      @(negedge clk);
      checkOutput("rst_valida", leitura_valida, 1'b0);
      checkOutput("rst_bitmap", bitmap_lido, 8'h00);
      checkOutput("rst_aceita", aceita_escrita, 1'b1);
      checkOutput("rst_mem_en", mem_en, 1'b0);
      checkOutput("rst_mem_we", mem_we, 1'b0);
      @(posedge clk); #2; rst_n = 1'b1;

      // Single lookup
      applyStimulus(1'b1, 8'h10, 1'b0, 8'h00, 3'd0, 1'b0);
      checkOutput("lk_mem_en", mem_en, 1'b1);
      checkOutput("lk_mem_we", mem_we, 1'b0);
      checkOutput("lk_addr", mem_endereco, 8'h10);
      checkOutput("lk_trava", trava, 1'b0);
      exp_lookup.push_back(8'hA5);
      idle();
      checkOutput("lk_valida", leitura_valida, 1'b1);
      checkOutput("lk_bitmap", bitmap_lido, 8'hA5);
      checkOutput("lk_idle_mem_en", mem_en, 1'b0);
      idle();
      checkOutput("lk_valida_off", leitura_valida, 1'b0);

      // Single update from idle: read, modify, write
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h20, 3'd3, 1'b1);
      checkOutput("up_aceita", aceita_escrita, 1'b1);
      checkOutput("up_push_mem_en", mem_en, 1'b0);
      exp_write.push_back({8'h20, 8'h08});
      idle();
      checkOutput("up_rd_en", mem_en, 1'b1);
      checkOutput("up_rd_we", mem_we, 1'b0);
      checkOutput("up_rd_addr", mem_endereco, 8'h20);
      idle();
      checkOutput("up_le_en", mem_en, 1'b0);
      idle();
      checkOutput("up_wr_en", mem_en, 1'b1);
      checkOutput("up_wr_we", mem_we, 1'b1);
      checkOutput("up_wr_addr", mem_endereco, 8'h20);
      checkOutput("up_wr_data", mem_dado_escrita, 8'h08);
      idle();
      checkOutput("up_after_en", mem_en, 1'b0);
      checkOutput("up_after_data", mem_dado_escrita, 8'h00);

      // One pending update under continuous lookups
      tab.push_back(mk(1, 8'h40, 1, 8'h30, 3'd0, 1, 0, 1, 8'h60, 8'h81));
      tab.push_back(mk(1, 8'h41, 0, 8'h00, 3'd0, 0, 0, 1, 8'h61, 8'h00));
      tab.push_back(mk(1, 8'h42, 0, 8'h00, 3'd0, 0, 0, 1, 8'h62, 8'h00));
      tab.push_back(mk(1, 8'h43, 0, 8'h00, 3'd0, 0, 0, 1, 8'h63, 8'h00));
      tab.push_back(mk(1, 8'h44, 0, 8'h00, 3'd0, 0, 0, 1, 8'h64, 8'h00));
      tab.push_back(mk(1, 8'h45, 0, 8'h00, 3'd0, 0, 1, 1, 8'h00, 8'h00));
      tab.push_back(mk(1, 8'h45, 0, 8'h00, 3'd0, 0, 1, 1, 8'h00, 8'h00));
      tab.push_back(mk(1, 8'h45, 0, 8'h00, 3'd0, 0, 1, 1, 8'h00, 8'h00));
      tab.push_back(mk(1, 8'h45, 0, 8'h00, 3'd0, 0, 0, 1, 8'h65, 8'h00));
      tab.push_back(mk(1, 8'h46, 0, 8'h00, 3'd0, 0, 0, 1, 8'h66, 8'h00));
      tab.push_back(mk(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, 1, 8'h00, 8'h00));
      runTable("starve");

      // Fill the queue under continuous lookups; full queue forces an update
      tab.push_back(mk(1, 8'h47, 1, 8'h50, 3'd0, 1, 0, 1, 8'h67, 8'h01));
      tab.push_back(mk(1, 8'h47, 1, 8'h51, 3'd1, 1, 0, 1, 8'h67, 8'h02));
      tab.push_back(mk(1, 8'h47, 1, 8'h30, 3'd7, 0, 0, 1, 8'h67, 8'h01));
      tab.push_back(mk(1, 8'h47, 1, 8'h53, 3'd3, 1, 0, 1, 8'h67, 8'h08));
      tab.push_back(mk(1, 8'h47, 1, 8'h54, 3'd4, 1, 1, 0, 8'h00, 8'h10));
      tab.push_back(mk(1, 8'h47, 1, 8'h54, 3'd4, 1, 1, 1, 8'h00, 8'h10));
      tab.push_back(mk(1, 8'h47, 0, 8'h00, 3'd0, 0, 1, 0, 8'h00, 8'h00));
      tab.push_back(mk(1, 8'h47, 0, 8'h00, 3'd0, 0, 1, 0, 8'h00, 8'h00));
      tab.push_back(mk(1, 8'h47, 0, 8'h00, 3'd0, 0, 1, 1, 8'h00, 8'h00));
      tab.push_back(mk(1, 8'h47, 0, 8'h00, 3'd0, 0, 1, 1, 8'h00, 8'h00));
      tab.push_back(mk(1, 8'h47, 0, 8'h00, 3'd0, 0, 0, 1, 8'h67, 8'h00));
      tab.push_back(mk(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, 1, 8'h00, 8'h00));
      runTable("full");
      for (int i = 0; i < 12; i++) idle();

      // Reset while writing back, with two updates still queued
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h60, 3'd1, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h61, 3'd2, 1'b1);
      checkOutput("rr_rd_addr", mem_endereco, 8'h60);
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h62, 3'd3, 1'b1);
      checkOutput("rr_le_en", mem_en, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      req_escrita = 1'b0;
      @(negedge clk);
      checkOutput("rr_mem_we", mem_we, 1'b0);
      checkOutput("rr_mem_en", mem_en, 1'b0);
      checkOutput("rr_aceita", aceita_escrita, 1'b1);
      @(posedge clk); #2; rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rr_rel_aceita", aceita_escrita, 1'b1);
      for (int i = 0; i < 4; i++) begin
         idle();
         checkOutput($sformatf("rr_idle%0d_en", i), mem_en, 1'b0);
      end
      applyStimulus(1'b1, 8'h10, 1'b0, 8'h00, 3'd0, 1'b0);
      checkOutput("rr_lk_trava", trava, 1'b0);
      checkOutput("rr_lk_en", mem_en, 1'b1);
      checkOutput("rr_lk_addr", mem_endereco, 8'h10);
      exp_lookup.push_back(8'hA5);
      for (int i = 0; i < 4; i++) idle();

      checkOutput("lookups_drained", exp_lookup.size(), 0);
      checkOutput("writes_drained", exp_write.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/controlador_matriz.md
CONTROLADOR_MATRIZ -- requirements
Module: controlador_matriz

Interface
REQ-001 SHALL have parameter NUM_CLUSTERS, default 8: bits per matrix entry (one per cluster).
REQ-002 SHALL have parameter TAM_HASH, default 8: matrix address width.
REQ-003 SHALL have parameter PROF_FILA, default 4: update FIFO depth (power of 2).
REQ-004 SHALL have parameter LIMITE_ESPERA, default 4: consecutive lookup grants tolerated while updates pend.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_leitura  in  1  lookup request.
- hash_leitura  in  TAM_HASH  lookup address.
- req_escrita  in  1  bit-update request.
- hash_escrita  in  TAM_HASH  update address.
- cluster_escrita  in  log2(NUM_CLUSTERS)  bit index to update.
- valor_escrita  in  1  new bit value.
- aceita_escrita  out  1  update accepted this cycle.
- mem_en  out  1  matrix port enable.
- mem_we  out  1  matrix write enable.
- mem_endereco  out  TAM_HASH  matrix address.
- mem_dado_escrita  out  NUM_CLUSTERS  write data.
- mem_dado_leitura  in  NUM_CLUSTERS  read data, valid 1 cycle after a read.
- leitura_valida  out  1  lookup result valid.
- bitmap_lido  out  NUM_CLUSTERS  lookup result.
- trava  out  1  lookup stalled this cycle.

Function
REQ-006 SHALL own a single-port matrix (one access per cycle, 1-cycle read latency), shared between lookups and read-modify-write bit updates.
REQ-007 SHALL buffer updates in a PROF_FILA-entry FIFO of {hash, cluster, valor}; aceita_escrita = FIFO not full (registered count); push when req_escrita && aceita_escrita.
REQ-008 SHALL allow push and pop in the same cycle when not full; count unchanged; a full FIFO SHALL NOT accept a push even if popping that cycle.
REQ-009 SHALL implement states OCIOSO, RMW_LE, RMW_ESCREVE.
REQ-010 In OCIOSO, an update SHALL be granted iff FIFO non-empty and (!req_leitura or FIFO full or contador_espera == LIMITE_ESPERA); otherwise a present lookup SHALL be granted.
REQ-011 Lookup grant: mem_en=1, mem_we=0, mem_endereco=hash_leitura; next cycle leitura_valida=1 and bitmap_lido=mem_dado_leitura; back-to-back lookups SHALL sustain one per cycle.
REQ-012 Update grant: pop FIFO head into holding register, mem_en=1, mem_we=0, mem_endereco=head hash; next state RMW_LE.
REQ-013 RMW_LE: no memory access; register mem_dado_leitura with bit cluster replaced by valor; next state RMW_ESCREVE.
REQ-014 RMW_ESCREVE: mem_en=1, mem_we=1, mem_endereco=held hash, mem_dado_escrita=registered value; next state OCIOSO. An update occupies exactly 3 cycles.
REQ-015 contador_espera SHALL increment (saturating at LIMITE_ESPERA) on each lookup grant while FIFO non-empty, and clear on update grant or when FIFO empty.
REQ-016 trava SHALL equal req_leitura && no lookup grant this cycle (includes RMW_LE, RMW_ESCREVE).
REQ-017 Stalled lookup inputs SHALL be held by requester; the block SHALL NOT latch them.
REQ-018 Lookups SHALL NOT be forwarded from pending FIFO entries; they return matrix contents as of the lookup read cycle.
REQ-019 mem_en=0 and mem_dado_escrita=0 in any cycle with no grant; leitura_valida=0 in cycles after no lookup grant.

Reset
REQ-020 rst_n low SHALL immediately force state OCIOSO, FIFO empty, contador_espera=0, leitura_valida=0, bitmap_lido=0, holding registers 0.
REQ-021 Reset during RMW_LE/RMW_ESCREVE SHALL abandon the write (mem_we=0 while reset asserted) and discard all pending updates.

Verification
REQ-022 Reset, then lookup hash 0x10 with memory returning 0xA5 -> mem_en=1,mem_we=0,addr 0x10; next cycle leitura_valida=1, bitmap_lido=0xA5, trava=0.
REQ-023 Idle, push {0x20,cluster 3,1}, memory holds 0x00 -> read 0x20, RMW_LE, write 0x08 to 0x20 in cycle 3.
REQ-024 Continuous lookups with one pending update -> 4 lookups granted, 5th cycle update granted, trava=1 for 3 cycles, then lookups resume.
REQ-025 Push 4 updates under continuous lookups -> aceita_escrita=0 after 4th; update granted next OCIOSO cycle; 5th push accepted only after count drops.
REQ-026 rst_n low in RMW_ESCREVE with 2 entries queued -> no write, FIFO empty, aceita_escrita=1, state OCIOSO after release.
